// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit_if
//  Description : Controller / instruction-memory / ALU-status signal bundle
//                for the instruction fetch unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_unit_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    // Controller side
    logic          FETCH_EN;
    logic [AW-1:0] PC;
    // Instruction memory side
    logic          IMEM_REQ;
    logic [AW-1:0] IMEM_ADDR;
    logic          IMEM_ACK;
    logic [31:0]   IMEM_RDATA;
    // Decoded instruction register
    logic          IR_VALID;
    logic [3:0]    OPCODE;
    logic [3:0]    MM;
    logic [3:0]    RD;
    logic [3:0]    RS;
    logic [15:0]   IMM;
    // Status register update from the ALU
    logic          STAT_WE;
    logic [DW-1:0] ALU_RESULT;
    logic          ALU_C;
    logic          ALU_V;
    logic [3:0]    STAT;
    // Condition outputs
    logic          BUSY;
    logic          HALT;
    logic          FETCH_ERR;

    // The fetch unit itself
    modport slave (
        input  FETCH_EN, PC, IMEM_ACK, IMEM_RDATA, STAT_WE, ALU_RESULT, ALU_C, ALU_V,
        output IMEM_REQ, IMEM_ADDR, IR_VALID, OPCODE, MM, RD, RS, IMM, STAT,
               BUSY, HALT, FETCH_ERR
    );

    // Controller / memory environment driving the fetch unit
    modport master (
        output FETCH_EN, PC, IMEM_ACK, IMEM_RDATA, STAT_WE, ALU_RESULT, ALU_C, ALU_V,
        input  IMEM_REQ, IMEM_ADDR, IR_VALID, OPCODE, MM, RD, RS, IMM, STAT,
               BUSY, HALT, FETCH_ERR
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : inst_fetch_unit
//  Description : Fetches one 32-bit instruction per FETCH_EN strobe over a
//                req/ack handshake, holds it in the IR, decodes its fields,
//                and maintains the {N,Z,V,C} status register.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_unit #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  wire logic         CLK,
    input  wire logic         RST_F,
    inst_fetch_unit_if.slave  bus
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] c_LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_wait;
    logic [31:0]   r_ir;
    logic          r_ir_valid;
    logic          r_halt;
    logic          r_err;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_stat;

    logic          w_start;
    logic          w_ack;
    logic          w_timeout;

    // A new fetch is only accepted from IDLE and never once halted or errored
    assign w_start   = (r_state == S_IDLE) && bus.FETCH_EN && !r_halt && !r_err;
    assign w_ack     = (r_state == S_REQ) && bus.IMEM_ACK;
    // The TIMEOUT-th consecutive unacknowledged request cycle is the last one
    assign w_timeout = (r_state == S_REQ) && !bus.IMEM_ACK && (r_wait == c_LAST_WAIT);

    // State register
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_REQ;
            S_REQ: begin
                if (w_ack) begin
                    w_next = S_IDLE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    // Fetch datapath: latched address, wait counter, IR and sticky flags
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            r_addr     <= '0;
            r_wait     <= '0;
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
            r_halt     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr     <= bus.PC;
                r_ir_valid <= 1'b0;
                r_wait     <= '0;
            end
            if (w_ack) begin
                r_ir       <= bus.IMEM_RDATA;
                r_ir_valid <= 1'b1;
            end else if (w_timeout) begin
                // Replace the IR with a no-op so the controller sees opcode 0
                r_ir       <= '0;
                r_err      <= 1'b1;
            end else if (r_state == S_REQ) begin
                r_wait     <= r_wait + 1'b1;
            end
            // Halt is flagged one edge after a halt instruction lands in the IR
            if (r_ir_valid && (r_ir[31:28] == 4'hF)) begin
                r_halt <= 1'b1;
            end
        end
    end

    // Status register, loaded from the ALU independently of the fetch FSM
    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            r_stat <= 4'b0000;
        end else if (bus.STAT_WE) begin
            r_stat <= {bus.ALU_RESULT[DW-1], (bus.ALU_RESULT == '0), bus.ALU_V, bus.ALU_C};
        end
    end

    assign bus.IMEM_REQ  = (r_state == S_REQ);
    assign bus.IMEM_ADDR = r_addr;
    assign bus.BUSY      = (r_state != S_IDLE);
    assign bus.IR_VALID  = r_ir_valid;
    assign bus.HALT      = r_halt;
    assign bus.FETCH_ERR = r_err;
    assign bus.STAT      = r_stat;
    assign bus.OPCODE    = r_ir[31:28];
    assign bus.MM        = r_ir[27:24];
    assign bus.RD        = r_ir[23:20];
    assign bus.RS        = r_ir[19:16];
    assign bus.IMM       = r_ir[15:0];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_fetch_unit
//  Description : Randomized scoreboard bench for inst_fetch_unit with a
//                behavioural instruction-memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_unit;

    localparam int AW      = 16;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  mm;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [15:0] imm;
    } fields_t;

    logic clk = 1'b0;
    logic rst_f;
    int   total = 0;
    int   bad   = 0;

    fields_t     sb[$];
    int          mem_delay = 1000;
    logic [31:0] mem_word  = '0;
    logic [15:0] exp_addr  = '0;
    logic        late_ack  = 1'b0;
    int          wcnt      = 0;
    logic [3:0]  exp_stat  = '0;

    inst_fetch_unit_if #(.AW(AW), .DW(DW)) bus ();

    inst_fetch_unit #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) u_dut (
        .CLK   (clk),
        .RST_F (rst_f),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected decode of a word, derived by shifting and masking the value
    function automatic fields_t decode(input logic [31:0] w);
        fields_t f;
        f.op  = 4'(w >> 28);
        f.mm  = 4'((w >> 24) & 32'hF);
        f.rd  = 4'((w >> 20) & 32'hF);
        f.rs  = 4'((w >> 16) & 32'hF);
        f.imm = 16'(w % 65536);
        return f;
    endfunction

    function automatic logic [3:0] stat_of(input logic [31:0] res, input bit v, input bit c);
        bit n;
        bit z;
        n = (res >= 32'h8000_0000);
        z = (res == 0);
        return {n, z, v, c};
    endfunction

    // Memory responder: acks after mem_delay request cycles, checks address stability
    always @(negedge clk) begin
        if (late_ack) begin
            bus.IMEM_ACK   = 1'b1;
            bus.IMEM_RDATA = 32'hDEAD_BEEF;
            wcnt           = 0;
        end else if (bus.IMEM_REQ) begin
            chk("imem_addr", 32'(bus.IMEM_ADDR), 32'(exp_addr));
            if (wcnt == mem_delay) begin
                bus.IMEM_ACK   = 1'b1;
                bus.IMEM_RDATA = mem_word;
            end else begin
                bus.IMEM_ACK   = 1'b0;
                bus.IMEM_RDATA = $urandom;
            end
            wcnt++;
        end else begin
            bus.IMEM_ACK   = 1'b0;
            bus.IMEM_RDATA = $urandom;
            wcnt           = 0;
        end
    end

    // Monitor: every new IR load is popped from the scoreboard and compared
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        fields_t e;
        if (bus.IR_VALID && !prev_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_ir_load", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("opcode", 32'(bus.OPCODE), 32'(e.op));
                chk("mm",     32'(bus.MM),     32'(e.mm));
                chk("rd",     32'(bus.RD),     32'(e.rd));
                chk("rs",     32'(bus.RS),     32'(e.rs));
                chk("imm",    32'(bus.IMM),    32'(e.imm));
            end
        end
        prev_valid = bus.IR_VALID;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_f = 1'b0;
        #1;
        exp_stat = '0;
        chk("rst_req",      32'(bus.IMEM_REQ),  0);
        chk("rst_ir_valid", 32'(bus.IR_VALID),  0);
        chk("rst_busy",     32'(bus.BUSY),      0);
        chk("rst_halt",     32'(bus.HALT),      0);
        chk("rst_err",      32'(bus.FETCH_ERR), 0);
        chk("rst_addr",     32'(bus.IMEM_ADDR), 0);
        chk("rst_stat",     32'(bus.STAT),      0);
        chk("rst_opcode",   32'(bus.OPCODE),    0);
        chk("rst_imm",      32'(bus.IMM),       0);
        @(negedge clk);
        rst_f = 1'b1;
    endtask

    task automatic do_fetch(input logic [15:0] pc, input logic [31:0] word, input int delay,
                            input bit with_stat, input logic [31:0] res, input bit v, input bit c);
        int n;
        int busy;
        @(negedge clk);
        mem_word     = word;
        mem_delay    = delay;
        exp_addr     = pc;
        bus.PC       = pc;
        bus.FETCH_EN = 1'b1;
        if (with_stat) begin
            bus.STAT_WE    = 1'b1;
            bus.ALU_RESULT = res;
            bus.ALU_V      = v;
            bus.ALU_C      = c;
            exp_stat       = stat_of(res, v, c);
        end
        sb.push_back(decode(word));
        @(negedge clk);
        bus.FETCH_EN = 1'b0;
        bus.STAT_WE  = 1'b0;
        bus.PC       = 16'($urandom);
        chk("req_after_strobe", 32'(bus.IMEM_REQ), 1);
        if (with_stat) chk("stat_with_fetch", 32'(bus.STAT), 32'(exp_stat));
        n    = 1;
        busy = 0;
        while (!bus.IR_VALID && n < delay + 20) begin
            if (bus.BUSY) busy++;
            @(negedge clk);
            bus.PC = 16'($urandom);
            n++;
        end
        chk("ir_valid_latency", n, delay + 2);
        chk("busy_cycles", busy, delay + 1);
        @(negedge clk);
        chk("halt_flag", 32'(bus.HALT), (word >> 28) == 15 ? 1 : 0);
    endtask

    task automatic stat_update(input logic [31:0] res, input bit v, input bit c);
        @(negedge clk);
        bus.STAT_WE    = 1'b1;
        bus.ALU_RESULT = res;
        bus.ALU_V      = v;
        bus.ALU_C      = c;
        exp_stat       = stat_of(res, v, c);
        @(negedge clk);
        bus.STAT_WE    = 1'b0;
        bus.ALU_RESULT = $urandom;
        bus.ALU_V      = 1'($urandom);
        bus.ALU_C      = 1'($urandom);
        chk("stat_load", 32'(bus.STAT), 32'(exp_stat));
        @(negedge clk);
        chk("stat_hold", 32'(bus.STAT), 32'(exp_stat));
    endtask

    // Issue a strobe that must be ignored and confirm no request appears
    task automatic ignored_strobe(input string name);
        @(negedge clk);
        bus.PC       = 16'($urandom);
        bus.FETCH_EN = 1'b1;
        @(negedge clk);
        bus.FETCH_EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk(name, 32'(bus.IMEM_REQ), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int reqc;
        logic [31:0] w;
        rst_f          = 1'b0;
        bus.FETCH_EN   = 1'b0;
        bus.PC         = '0;
        bus.STAT_WE    = 1'b0;
        bus.ALU_RESULT = '0;
        bus.ALU_V      = 1'b0;
        bus.ALU_C      = 1'b0;
        do_reset();

        // Zero-wait fetch and a wait-state fetch with PC wiggling during REQ
        do_fetch(16'h0010, 32'h8A3F_0005, 0, 1'b0, '0, 1'b0, 1'b0);
        do_fetch(16'h0123, 32'h1234_ABCD, 3, 1'b0, '0, 1'b0, 1'b0);

        // Random fetches, some with a concurrent STAT update
        for (int i = 0; i < 8; i++) begin
            w = {4'($urandom_range(0, 14)), 28'($urandom)};
            do_fetch(16'($urandom), w, $urandom_range(0, 10), 1'($urandom),
                     $urandom, 1'($urandom), 1'($urandom));
        end

        // Status register corner values and a concurrent fetch/update
        stat_update(32'h0000_0000, 1'b0, 1'b1);
        stat_update(32'h8000_0000, 1'b1, 1'b0);
        stat_update(32'h0000_0001, 1'b0, 1'b0);
        do_fetch(16'h0200, 32'h3456_7890, 1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);

        // Halt instruction blocks further fetches
        do_fetch(16'h0300, 32'hF000_0000, 1, 1'b0, '0, 1'b0, 1'b0);
        ignored_strobe("req_while_halted");
        do_reset();

        // Reset while a request is outstanding, late ACK afterwards
        @(negedge clk);
        mem_delay    = 1000;
        exp_addr     = 16'h0444;
        bus.PC       = 16'h0444;
        bus.FETCH_EN = 1'b1;
        @(negedge clk);
        bus.FETCH_EN = 1'b0;
        @(negedge clk);
        chk("req_before_reset", 32'(bus.IMEM_REQ), 1);
        #2;
        rst_f = 1'b0;
        #1;
        chk("req_drop_on_reset", 32'(bus.IMEM_REQ), 0);
        exp_stat = '0;
        late_ack = 1'b1;
        @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);
        @(negedge clk);
        late_ack = 1'b0;
        chk("no_stale_ir_valid", 32'(bus.IR_VALID), 0);
        chk("no_stale_opcode",   32'(bus.OPCODE),   0);
        do_fetch(16'h0555, 32'h7654_3210, 0, 1'b0, '0, 1'b0, 1'b0);

        // Timeout: no ACK ever arrives
        @(negedge clk);
        mem_delay    = 1000;
        exp_addr     = 16'h0666;
        bus.PC       = 16'h0666;
        bus.FETCH_EN = 1'b1;
        @(negedge clk);
        bus.FETCH_EN = 1'b0;
        n    = 1;
        reqc = 0;
        while (!bus.FETCH_ERR && n < 40) begin
            if (bus.IMEM_REQ) reqc++;
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", n, TIMEOUT + 1);
        chk("timeout_req_cycles", reqc, TIMEOUT);
        chk("err_opcode",   32'(bus.OPCODE),   0);
        chk("err_req",      32'(bus.IMEM_REQ), 0);
        chk("err_ir_valid", 32'(bus.IR_VALID), 0);
        chk("err_busy",     32'(bus.BUSY),     1);
        chk("err_stat",     32'(bus.STAT),     32'(exp_stat));
        ignored_strobe("req_after_error");
        chk("err_sticky", 32'(bus.FETCH_ERR), 1);
        do_reset();
        do_fetch(16'h0777, 32'h2BAD_C0DE, 2, 1'b0, '0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
